// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared CPU constants, control-bundle layout and EX register type
package id_ex_stage_pkg;

    localparam int CTRL_W = 19;
    localparam logic [4:0] REG_LINK = 5'd31;

    // Bit positions of the decoder bundle, MSB first
    localparam int CTRL_BEQ        = 18;
    localparam int CTRL_BNE        = 17;
    localparam int CTRL_MEM_TO_REG = 16;
    localparam int CTRL_MEM_WRITE  = 15;
    localparam int CTRL_ALU_OP_LSB = 11;
    localparam int CTRL_ALU_SRC_B  = 10;
    localparam int CTRL_REG_WRITE  = 9;
    localparam int CTRL_REG_DST    = 8;
    localparam int CTRL_SIGNED_EXT = 7;
    localparam int CTRL_JAL        = 6;
    localparam int CTRL_JMP        = 5;
    localparam int CTRL_JR         = 4;
    localparam int CTRL_SYSCALL    = 3;
    localparam int CTRL_MY_A_LSB   = 1;
    localparam int CTRL_MY_B       = 0;

    typedef logic [CTRL_W-1:0] ctrl_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm32;
        logic [4:0]  wr_reg;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        ctrl_t       ctrl;
    } ex_reg_t;

    function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic sext);
        return sext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID-side inputs and EX-side outputs of the ID/EX pipeline register
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [15:0] id_imm16;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    ctrl_t       id_ctrl;
    logic        ex_flush;
    logic        mem_stall;

    logic        id_stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm32;
    logic [4:0]  ex_wr_reg;
    logic [4:0]  ex_shamt;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    ctrl_t       ex_ctrl;
    logic [15:0] bubble_cnt;

    modport slave (
        input  id_valid, id_pc, id_rs, id_rt, id_rd, id_shamt, id_imm16,
               id_rs_data, id_rt_data, id_ctrl, ex_flush, mem_stall,
        output id_stall, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm32,
               ex_wr_reg, ex_shamt, ex_rs, ex_rt, ex_ctrl, bubble_cnt
    );

    modport master (
        output id_valid, id_pc, id_rs, id_rt, id_rd, id_shamt, id_imm16,
               id_rs_data, id_rt_data, id_ctrl, ex_flush, mem_stall,
        input  id_stall, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm32,
               ex_wr_reg, ex_shamt, ex_rs, ex_rt, ex_ctrl, bubble_cnt
    );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// rtl/id_ex_stage_load_use_detect.sv - combinational load-use hazard detector
module load_use_detect (
    input  logic       ex_valid_i,
    input  logic       ex_mem_to_reg_i,
    input  logic [4:0] ex_wr_reg_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_jmp_i,
    input  logic       id_jal_i,
    input  logic       id_syscall_i,
    input  logic       id_reg_dst_i,
    input  logic       id_mem_write_i,
    input  logic       id_beq_i,
    input  logic       id_bne_i,
    output logic       hazard_o
);

    logic uses_rs;
    logic uses_rt;

    assign uses_rs = ~(id_jmp_i | id_jal_i | id_syscall_i);
    assign uses_rt = id_reg_dst_i | id_mem_write_i | id_beq_i | id_bne_i;

    // $0 never carries a real dependency, so a load into it cannot stall
    assign hazard_o = ex_valid_i & ex_mem_to_reg_i & (ex_wr_reg_i != 5'd0) & id_valid_i &
                      (((ex_wr_reg_i == id_rs_i) & uses_rs) |
                       ((ex_wr_reg_i == id_rt_i) & uses_rt));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubbling and bubble counter
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);

    ex_reg_t     ex_q;
    ex_reg_t     ex_d;
    logic [15:0] bubble_cnt_q;
    logic [15:0] bubble_cnt_d;
    logic        bubble_inc;
    logic        hazard;
    logic [4:0]  wr_reg_sel;

    load_use_detect u_load_use_detect (
        .ex_valid_i      (ex_q.valid),
        .ex_mem_to_reg_i (ex_q.ctrl[CTRL_MEM_TO_REG]),
        .ex_wr_reg_i     (ex_q.wr_reg),
        .id_valid_i      (bus.id_valid),
        .id_rs_i         (bus.id_rs),
        .id_rt_i         (bus.id_rt),
        .id_jmp_i        (bus.id_ctrl[CTRL_JMP]),
        .id_jal_i        (bus.id_ctrl[CTRL_JAL]),
        .id_syscall_i    (bus.id_ctrl[CTRL_SYSCALL]),
        .id_reg_dst_i    (bus.id_ctrl[CTRL_REG_DST]),
        .id_mem_write_i  (bus.id_ctrl[CTRL_MEM_WRITE]),
        .id_beq_i        (bus.id_ctrl[CTRL_BEQ]),
        .id_bne_i        (bus.id_ctrl[CTRL_BNE]),
        .hazard_o        (hazard)
    );

    always_comb begin
        wr_reg_sel = bus.id_rt;
        if (bus.id_ctrl[CTRL_REG_DST]) begin
            wr_reg_sel = bus.id_rd;
        end else if (bus.id_ctrl[CTRL_JAL]) begin
            wr_reg_sel = REG_LINK;
        end
    end

    // Flush beats stall beats hazard beats a normal load
    always_comb begin
        ex_d       = ex_q;
        bubble_inc = 1'b0;
        if (bus.ex_flush) begin
            ex_d = '0;
        end else if (bus.mem_stall) begin
            ex_d = ex_q;
        end else if (hazard) begin
            ex_d       = '0;
            bubble_inc = (bubble_cnt_q != 16'hFFFF);
        end else begin
            ex_d.valid   = bus.id_valid;
            ex_d.pc      = bus.id_pc;
            ex_d.rs_data = bus.id_rs_data;
            ex_d.rt_data = bus.id_rt_data;
            ex_d.imm32   = ext_imm(bus.id_imm16, bus.id_ctrl[CTRL_SIGNED_EXT]);
            ex_d.wr_reg  = wr_reg_sel;
            ex_d.shamt   = bus.id_shamt;
            ex_d.rs      = bus.id_rs;
            ex_d.rt      = bus.id_rt;
            ex_d.ctrl    = bus.id_valid ? bus.id_ctrl : '0;
        end
    end

    assign bubble_cnt_d = bubble_cnt_q + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= 16'h0000;
        end else if (bubble_inc) begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.id_stall   = hazard & ~bus.ex_flush & ~bus.mem_stall;
    assign bus.ex_valid   = ex_q.valid;
    assign bus.ex_pc      = ex_q.pc;
    assign bus.ex_rs_data = ex_q.rs_data;
    assign bus.ex_rt_data = ex_q.rt_data;
    assign bus.ex_imm32   = ex_q.imm32;
    assign bus.ex_wr_reg  = ex_q.wr_reg;
    assign bus.ex_shamt   = ex_q.shamt;
    assign bus.ex_rs      = ex_q.rs;
    assign bus.ex_rt      = ex_q.rt;
    assign bus.ex_ctrl    = ex_q.ctrl;
    assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_stage_if bus();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    localparam ctrl_t B1     = ctrl_t'(1);
    localparam ctrl_t C_ADDI = (B1 << CTRL_REG_WRITE) | (B1 << CTRL_ALU_SRC_B) | (B1 << CTRL_SIGNED_EXT);
    localparam ctrl_t C_ORI  = (B1 << CTRL_REG_WRITE) | (B1 << CTRL_ALU_SRC_B) | (ctrl_t'(5) << CTRL_ALU_OP_LSB);
    localparam ctrl_t C_ADD  = (B1 << CTRL_REG_WRITE) | (B1 << CTRL_REG_DST) | (ctrl_t'(2) << CTRL_ALU_OP_LSB);
    localparam ctrl_t C_LW   = (B1 << CTRL_MEM_TO_REG) | (B1 << CTRL_REG_WRITE) | (B1 << CTRL_ALU_SRC_B) | (B1 << CTRL_SIGNED_EXT);
    localparam ctrl_t C_SW   = (B1 << CTRL_MEM_WRITE) | (B1 << CTRL_ALU_SRC_B) | (B1 << CTRL_SIGNED_EXT);
    localparam ctrl_t C_BEQ  = (B1 << CTRL_BEQ) | (B1 << CTRL_SIGNED_EXT) | (ctrl_t'(6) << CTRL_ALU_OP_LSB);
    localparam ctrl_t C_JAL  = (B1 << CTRL_JAL) | (B1 << CTRL_REG_WRITE) | (B1 << CTRL_MY_B);
    localparam ctrl_t C_J    = (B1 << CTRL_JMP) | (ctrl_t'(3) << CTRL_MY_A_LSB);
    localparam ctrl_t C_JR   = (B1 << CTRL_JR);

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs, rt, rd, shamt;
        logic [15:0] imm;
        logic [31:0] rs_data, rt_data;
        ctrl_t       ctrl;
        logic [31:0] e_imm32;
        logic [4:0]  e_wr;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc, rs_data, rt_data, imm32;
        logic [4:0]  wr, shamt, rs, rt;
        ctrl_t       ctrl;
    } exp_t;

    exp_t sb[$];

    function automatic vec_t mkv(input logic v, input logic [31:0] pc, input logic [4:0] rs, rt, rd, sh,
                                 input logic [15:0] imm, input logic [31:0] rsd, rtd, input ctrl_t c,
                                 input logic [31:0] eimm, input logic [4:0] ewr);
        vec_t r;
        r.valid = v; r.pc = pc; r.rs = rs; r.rt = rt; r.rd = rd; r.shamt = sh; r.imm = imm;
        r.rs_data = rsd; r.rt_data = rtd; r.ctrl = c; r.e_imm32 = eimm; r.e_wr = ewr;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic drv(input logic v, input logic [31:0] pc, input logic [4:0] rs, rt, rd,
                       input logic [15:0] imm, input ctrl_t c);
        bus.id_valid   = v;
        bus.id_pc      = pc;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_rd      = rd;
        bus.id_shamt   = rd ^ 5'h01;
        bus.id_imm16   = imm;
        bus.id_rs_data = pc + 32'h1000;
        bus.id_rt_data = pc + 32'h2000;
        bus.id_ctrl    = c;
    endtask

    // Puts lw $lw_rt into EX, presents a candidate in ID, checks stall, bubble and follow-up
    task automatic hz_case(input string nm, input logic [4:0] lw_rt, input logic cv,
                           input logic [4:0] rs, rt, rd, input ctrl_t c,
                           input logic exp_stall, input logic [15:0] exp_cnt);
        @(negedge clk);
        drv(1'b1, 32'h400, 5'd29, lw_rt, 5'd0, 16'h0010, C_LW);
        @(negedge clk);
        drv(cv, 32'h404, rs, rt, rd, 16'h0004, c);
        #1;
        chk({nm, " id_stall"}, 32'(bus.id_stall), 32'(exp_stall));
        @(negedge clk);
        chk({nm, " bubble_cnt"}, 32'(bus.bubble_cnt), 32'(exp_cnt));
        chk({nm, " ex_valid"}, 32'(bus.ex_valid), 32'(cv & ~exp_stall));
        if (exp_stall) begin
            @(negedge clk);
            chk({nm, " enter ex_pc"}, bus.ex_pc, 32'h404);
            chk({nm, " enter ex_valid"}, 32'(bus.ex_valid), 32'd1);
        end
    endtask

    initial begin
        vec_t tbl[9];
        exp_t e;

        tbl[0] = mkv(1, 32'h100, 3, 4, 0, 0, 16'h8001, 32'h11111111, 32'h22222222, C_ADDI, 32'hFFFF8001, 4);
        tbl[1] = mkv(1, 32'h104, 3, 5, 0, 0, 16'h8001, 32'hAAAA5555, 32'h0F0F0F0F, C_ORI, 32'h00008001, 5);
        tbl[2] = mkv(1, 32'h108, 6, 7, 10, 3, 16'h5020, 32'h12345678, 32'h9ABCDEF0, C_ADD, 32'h00005020, 10);
        tbl[3] = mkv(1, 32'h10C, 0, 7, 0, 0, 16'h0040, 32'h00000001, 32'h00000002, C_JAL, 32'h00000040, 31);
        tbl[4] = mkv(0, 32'h110, 1, 2, 12, 1, 16'h6000, 32'hDEADBEEF, 32'hCAFEF00D, C_ADD, 32'h00006000, 12);
        tbl[5] = mkv(1, 32'h114, 29, 9, 0, 0, 16'h7FFF, 32'h7FFF0000, 32'h00000009, C_SW, 32'h00007FFF, 9);
        tbl[6] = mkv(1, 32'h118, 1, 2, 0, 0, 16'hFFFC, 32'h00000005, 32'h00000005, C_BEQ, 32'hFFFFFFFC, 2);
        tbl[7] = mkv(1, 32'h11C, 0, 3, 20, 0, 16'hA000, 32'h0000AAAA, 32'h0000BBBB, C_JAL | (B1 << CTRL_REG_DST), 32'h0000A000, 20);
        tbl[8] = mkv(1, 32'h120, 4, 5, 0, 31, 16'hFFFF, 32'hFFFFFFFF, 32'h80000000, C_ORI, 32'h0000FFFF, 5);

        rst_n = 1'b0;
        bus.ex_flush = 1'b0;
        bus.mem_stall = 1'b0;
        drv(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 16'h0, '0);
        @(negedge clk);
        @(negedge clk);
        chk("reset ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("reset ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
        chk("reset ex_pc", bus.ex_pc, 32'd0);
        chk("reset ex_imm32", bus.ex_imm32, 32'd0);
        chk("reset bubble_cnt", 32'(bus.bubble_cnt), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i <= 9; i++) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("vec ex_valid", 32'(bus.ex_valid), 32'(e.valid));
                chk("vec ex_pc", bus.ex_pc, e.pc);
                chk("vec ex_rs_data", bus.ex_rs_data, e.rs_data);
                chk("vec ex_rt_data", bus.ex_rt_data, e.rt_data);
                chk("vec ex_imm32", bus.ex_imm32, e.imm32);
                chk("vec ex_wr_reg", 32'(bus.ex_wr_reg), 32'(e.wr));
                chk("vec ex_shamt", 32'(bus.ex_shamt), 32'(e.shamt));
                chk("vec ex_rs", 32'(bus.ex_rs), 32'(e.rs));
                chk("vec ex_rt", 32'(bus.ex_rt), 32'(e.rt));
                chk("vec ex_ctrl", 32'(bus.ex_ctrl), 32'(e.ctrl));
            end
            if (i < 9) begin
                bus.id_valid = tbl[i].valid;   bus.id_pc = tbl[i].pc;
                bus.id_rs = tbl[i].rs;         bus.id_rt = tbl[i].rt;
                bus.id_rd = tbl[i].rd;         bus.id_shamt = tbl[i].shamt;
                bus.id_imm16 = tbl[i].imm;     bus.id_ctrl = tbl[i].ctrl;
                bus.id_rs_data = tbl[i].rs_data; bus.id_rt_data = tbl[i].rt_data;
                e.valid = tbl[i].valid;        e.pc = tbl[i].pc;
                e.rs_data = tbl[i].rs_data;    e.rt_data = tbl[i].rt_data;
                e.imm32 = tbl[i].e_imm32;      e.wr = tbl[i].e_wr;
                e.shamt = tbl[i].shamt;        e.rs = tbl[i].rs;   e.rt = tbl[i].rt;
                e.ctrl = tbl[i].valid ? tbl[i].ctrl : '0;
                sb.push_back(e);
            end
        end
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        hz_case("lu add rs", 5'd8, 1'b1, 5'd8, 5'd9, 5'd10, C_ADD, 1'b1, 16'd1);
        hz_case("lu sw rt", 5'd9, 1'b1, 5'd29, 5'd9, 5'd0, C_SW, 1'b1, 16'd2);
        hz_case("addi rt unused", 5'd9, 1'b1, 5'd2, 5'd9, 5'd0, C_ADDI, 1'b0, 16'd2);
        hz_case("j rs unused", 5'd8, 1'b1, 5'd8, 5'd0, 5'd0, C_J, 1'b0, 16'd2);
        hz_case("lw zero", 5'd0, 1'b1, 5'd0, 5'd0, 5'd3, C_ADD, 1'b0, 16'd2);
        hz_case("id invalid", 5'd8, 1'b0, 5'd8, 5'd9, 5'd10, C_ADD, 1'b0, 16'd2);
        hz_case("lu beq rt", 5'd8, 1'b1, 5'd1, 5'd8, 5'd0, C_BEQ, 1'b1, 16'd3);
        hz_case("lu jr rs", 5'd8, 1'b1, 5'd8, 5'd0, 5'd0, C_JR, 1'b1, 16'd4);

        @(negedge clk);
        drv(1'b1, 32'h300, 5'd29, 5'd8, 5'd0, 16'h0020, C_LW);
        @(negedge clk);
        drv(1'b1, 32'h304, 5'd8, 5'd9, 5'd10, 16'h0000, C_ADD);
        bus.mem_stall = 1'b1;
        #1;
        chk("stall masks id_stall", 32'(bus.id_stall), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold ex_pc", bus.ex_pc, 32'h300);
            chk("hold ex_valid", 32'(bus.ex_valid), 32'd1);
            chk("hold ex_ctrl", 32'(bus.ex_ctrl), 32'(C_LW));
            chk("hold ex_wr_reg", 32'(bus.ex_wr_reg), 32'd8);
            chk("hold ex_imm32", bus.ex_imm32, 32'h20);
            drv(1'b1, 32'h308 + 32'(4 * k), 5'(k), 5'(k + 1), 5'(k + 2), 16'(16'h9000 + k), C_ADDI);
        end
        bus.ex_flush = 1'b1;
        @(negedge clk);
        chk("flush+stall ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("flush+stall ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
        chk("flush+stall ex_pc", bus.ex_pc, 32'd0);
        chk("flush+stall bubble_cnt", 32'(bus.bubble_cnt), 32'd4);
        bus.ex_flush = 1'b0;
        bus.mem_stall = 1'b0;

        @(negedge clk);
        drv(1'b1, 32'h500, 5'd29, 5'd8, 5'd0, 16'h0008, C_LW);
        @(negedge clk);
        drv(1'b1, 32'h504, 5'd8, 5'd9, 5'd10, 16'h0000, C_ADD);
        bus.ex_flush = 1'b1;
        #1;
        chk("flush masks id_stall", 32'(bus.id_stall), 32'd0);
        @(negedge clk);
        chk("flush ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("flush not counted", 32'(bus.bubble_cnt), 32'd4);
        bus.ex_flush = 1'b0;
        @(negedge clk);
        chk("after flush ex_pc", bus.ex_pc, 32'h504);
        chk("after flush ex_valid", 32'(bus.ex_valid), 32'd1);

        drv(1'b1, 32'h600, 5'd0, 5'd5, 5'd0, 16'h0100, C_JAL);
        @(negedge clk);
        chk("jal ex_wr_reg", 32'(bus.ex_wr_reg), 32'd31);
        chk("jal ex_ctrl", 32'(bus.ex_ctrl), 32'(C_JAL));

        force dut.bubble_cnt_q = 16'hFFFF;
        #1;
        release dut.bubble_cnt_q;
        hz_case("saturate", 5'd8, 1'b1, 5'd8, 5'd9, 5'd10, C_ADD, 1'b1, 16'hFFFF);

        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("async rst ex_pc", bus.ex_pc, 32'd0);
        chk("async rst ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
        chk("async rst ex_rs_data", bus.ex_rs_data, 32'd0);
        chk("async rst bubble_cnt", 32'(bus.bubble_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        drv(1'b1, 32'h700, 5'd1, 5'd2, 5'd0, 16'h0007, C_ADDI);
        @(negedge clk);
        chk("pre-stall ex_valid", 32'(bus.ex_valid), 32'd1);
        bus.mem_stall = 1'b1;
        @(negedge clk);
        chk("stalled ex_pc", bus.ex_pc, 32'h700);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst mid-stall ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst mid-stall ex_pc", bus.ex_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst stall ex_valid", 32'(bus.ex_valid), 32'd0);
        bus.mem_stall = 1'b0;
        drv(1'b1, 32'h710, 5'd1, 5'd2, 5'd0, 16'h8000, C_ADDI);
        @(negedge clk);
        chk("post-rst load ex_pc", bus.ex_pc, 32'h710);
        chk("post-rst load ex_imm32", bus.ex_imm32, 32'hFFFF8000);
        chk("post-rst load ex_valid", 32'(bus.ex_valid), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_pc  in  32  PC of ID instruction
- id_rs, id_rt, id_rd, id_shamt  in  5 each  instruction fields
- id_imm16  in  16  immediate field
- id_rs_data, id_rt_data  in  32 each  register-file read data
- id_ctrl  in  19  decoder bundle {beq, bne, mem_to_reg, mem_write, alu_op[3:0], alu_src_b, reg_write, reg_dst, signed_ext, jal, jmp, jr, syscall, my_A_signal[1:0], my_B_signal}
- ex_flush  in  1  kill ID->EX transfer (branch/jump resolved)
- mem_stall  in  1  downstream stall; freeze EX register
- id_stall  out  1  load-use hazard; IF and IF/ID SHALL hold
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_rs_data, ex_rt_data, ex_imm32  out  32 each  registered operands
- ex_wr_reg, ex_shamt, ex_rs, ex_rt  out  5 each  registered fields
- ex_ctrl  out  19  registered control bundle, same ordering as id_ctrl
- bubble_cnt  out  16  inserted-bubble counter

Function
REQ-002 ex_imm32 SHALL be sign-extended id_imm16 when signed_ext=1, else zero-extended.
REQ-003 ex_wr_reg SHALL latch id_rd if reg_dst=1, else 31 if jal=1, else id_rt.
REQ-004 Load-use hazard SHALL be ex_valid & ex mem_to_reg & ex_wr_reg!=0 & id_valid & ((ex_wr_reg==id_rs & uses_rs) | (ex_wr_reg==id_rt & uses_rt)), combinational.
REQ-005 uses_rs SHALL be ~(jmp|jal|syscall); uses_rt SHALL be reg_dst|mem_write|beq|bne.
REQ-006 id_stall SHALL equal hazard & ~ex_flush & ~mem_stall.
REQ-007 Per-edge priority SHALL be: ex_flush > mem_stall > hazard > normal load.
REQ-008 ex_flush=1: EX register SHALL load a bubble (ex_valid=0, ex_ctrl=0, datapath 0), regardless of mem_stall.
REQ-009 mem_stall=1 (no flush): every EX output SHALL hold its value.
REQ-010 Hazard (no flush, no stall): EX SHALL load a bubble; bubble_cnt SHALL increment.
REQ-011 Normal: EX SHALL load all ID fields; ex_valid=id_valid; ex_ctrl SHALL be forced to 0 when id_valid=0.
REQ-012 Latency SHALL be one cycle ID->EX; no combinational path from id_* to ex_* outputs.
REQ-013 bubble_cnt SHALL saturate at 16'hFFFF and count only hazard bubbles, not flushes.
REQ-014 A hazard SHALL last exactly one cycle for a single load (bubble clears ex_valid).

Reset
REQ-015 rst_n=0 SHALL asynchronously clear every register: ex_valid=0, ex_ctrl=0, all datapath outputs 0, bubble_cnt=0.
REQ-016 Reset mid-stall SHALL discard held instruction; first edge after deassertion SHALL follow REQ-007.

Structure
REQ-017 Control-bundle width (19), bit-position constants of id_ctrl fields and link register number 31 SHALL live in the shared CPU package.
REQ-018 Hazard detection SHALL be a sub-module load_use_detect (pure combinational); pipeline register and counter in id_ex_stage.

Verification
REQ-019 addi with id_ctrl reg_write=1, imm16=16'h8001, signed_ext=1 -> next cycle ex_imm32=32'hFFFF8001, ex_wr_reg=id_rt, ex_valid=1.
REQ-020 lw $8 in EX, ID add rs=8 -> id_stall=1 one cycle, EX gets bubble, bubble_cnt 0->1; next cycle add enters EX.
REQ-021 lw $0 in EX, ID rs=0 -> id_stall=0, no bubble.
REQ-022 mem_stall=1 for 3 cycles with ID changing -> EX outputs constant; ex_flush=1 with mem_stall=1 -> ex_valid=0 next edge.
REQ-023 jal in ID, reg_dst=0 -> ex_wr_reg=31; bubble_cnt forced to FFFF then hazard -> stays FFFF.
REQ-024 rst_n asserted mid-cycle with valid EX -> outputs zero immediately, without clock edge.
